// File: rtl/folded_fir_ctrl.sv
// rtl/folded_fir_ctrl.sv - Sequencer for the 5-tap folded FIR with one shared MAC
//
// Purpose:
//   Drives the folded FIR datapath from the single fast clock. Every sample
//   takes TAPS MAC cycles. The first of them raises sample_en and acc_clr,
//   and the cycle after the last one raises out_valid. A run processes the
//   number of samples captured at start. hold freezes the sequence without
//   losing or repeating a MAC cycle.
//
// Optional feature (macro FOLDED_FIR_CTRL_COEF_REG_EN):
//   Adds an internal bank of TAPS signed coefficients with a write port.
//   Adds coef_out, which is registered coef[tap_sel] and changes with
//   tap_sel. Without the macro the datapath muxes its external c0..c4 by
//   tap_sel.
//
// Ports:
//   clk100       in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   start        in   begin a run (sampled only in IDLE)
//   num_samples  in   samples to process, captured with start
//   hold         in   stall; freezes the sequence while high
//   busy         out  run in progress
//   done         out  one-cycle end-of-run pulse
//   tap_sel      out  tap index of the current MAC cycle
//   mem_addr     out  input-memory address of the current sample
//   sample_en    out  shift the delay line / load a new sample (tap 0)
//   acc_clr      out  accumulator loads the product instead of adding (tap 0)
//   acc_en       out  MAC cycle active
//   out_valid    out  accumulator holds a finished output
//   coef_we      in   coefficient write enable     (optional)
//   coef_waddr   in   coefficient write index      (optional)
//   coef_wdata   in   coefficient write data       (optional)
//   coef_out     out  coefficient for tap_sel      (optional)

module folded_fir_ctrl #(
  parameter int TAPS   = 5,
  parameter int TAP_W  = 3,
  parameter int ADDR_W = 8,
  parameter int COEF_W = 12
) (
  input  logic                     clk100,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        num_samples,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic [TAP_W-1:0]         tap_sel,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     sample_en,
  output logic                     acc_clr,
  output logic                     acc_en,
  output logic                     out_valid
`ifdef FOLDED_FIR_CTRL_COEF_REG_EN
  ,
  input  logic                     coef_we,
  input  logic [TAP_W-1:0]         coef_waddr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic signed [COEF_W-1:0] coef_out
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  if (((1 << TAP_W) < TAPS) || (COEF_W < 1)) begin : g_bad_params
    $error("folded_fir_ctrl: TAP_W too narrow for TAPS, or COEF_W < 1");
  end

  state_t            state, state_d;
  logic [ADDR_W-1:0] n_reg, n_d;
  logic              busy_d, done_d, sample_en_d, acc_clr_d, acc_en_d, out_valid_d;
  logic [TAP_W-1:0]  tap_d;
  logic [ADDR_W-1:0] addr_d;

  // The registered tap_sel/mem_addr always name the most recently issued
  // MAC cycle. A held cycle (acc_en=0) keeps that position, so releasing
  // hold simply advances from it: nothing is lost and nothing is repeated.
  logic last_issue;
  logic last_sample;
  assign last_issue  = acc_en && (tap_sel == LAST_TAP);
  assign last_sample = (mem_addr == (n_reg - ADDR_W'(1)));

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      n_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tap_sel   <= '0;
      mem_addr  <= '0;
      sample_en <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      n_reg     <= n_d;
      busy      <= busy_d;
      done      <= done_d;
      tap_sel   <= tap_d;
      mem_addr  <= addr_d;
      sample_en <= sample_en_d;
      acc_clr   <= acc_clr_d;
      acc_en    <= acc_en_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state;
    n_d         = n_reg;
    busy_d      = busy;
    done_d      = 1'b0;
    tap_d       = tap_sel;
    addr_d      = mem_addr;
    sample_en_d = 1'b0;
    acc_clr_d   = 1'b0;
    acc_en_d    = 1'b0;
    out_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (num_samples != '0) begin
            n_d         = num_samples;
            state_d     = RUN;
            busy_d      = 1'b1;
            tap_d       = '0;
            addr_d      = '0;
            sample_en_d = 1'b1;
            acc_clr_d   = 1'b1;
            acc_en_d    = 1'b1;
          end else begin
            // An empty run completes at once.
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        // The output of a finished sample appears in the cycle after its
        // last tap, even if hold rises in that same cycle.
        out_valid_d = last_issue;
        if (last_issue && last_sample) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tap_d   = '0;
          addr_d  = mem_addr + ADDR_W'(1);
        end else if (!hold) begin
          acc_en_d = 1'b1;
          if (tap_sel == LAST_TAP) begin
            tap_d       = '0;
            addr_d      = mem_addr + ADDR_W'(1);
            sample_en_d = 1'b1;
            acc_clr_d   = 1'b1;
          end else begin
            tap_d = tap_sel + TAP_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef FOLDED_FIR_CTRL_COEF_REG_EN
  logic signed [COEF_W-1:0] coef [TAPS];
  logic                     coef_wr_ok;

  // Writes are accepted only between runs, so coefficients never change under
  // a running sequence.
  assign coef_wr_ok = coef_we && !busy && (int'(coef_waddr) < TAPS);

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
      coef_out <= '0;
    end else begin
      if (coef_wr_ok) begin
        coef[coef_waddr] <= coef_wdata;
      end
      // Look up the tap that tap_sel takes next, so that coef_out and tap_sel
      // change on the same edge. A write to that tap in the same cycle is
      // forwarded.
      if (coef_wr_ok && (coef_waddr == tap_d)) begin
        coef_out <= coef_wdata;
      end else begin
        coef_out <= coef[tap_d];
      end
    end
  end
`endif

endmodule

// File: tb/tb_folded_fir_ctrl.sv
// tb/tb_folded_fir_ctrl.sv - Self-checking bench for folded_fir_ctrl
module tb_folded_fir_ctrl;
  localparam int TAPS   = 5;
  localparam int TAP_W  = 3;
  localparam int ADDR_W = 8;
  localparam int COEF_W = 12;

  logic              clk100 = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] num_samples = '0;
  logic              busy, done, sample_en, acc_clr, acc_en, out_valid;
  logic [TAP_W-1:0]  tap_sel;
  logic [ADDR_W-1:0] mem_addr;
`ifdef FOLDED_FIR_CTRL_COEF_REG_EN
  logic              coef_we = 1'b0;
  logic [TAP_W-1:0]  coef_waddr = '0;
  logic [COEF_W-1:0] coef_wdata = '0;
  logic [COEF_W-1:0] coef_out;
`endif

  int checks = 0;
  int passes = 0;

  // {busy, done, tap_sel, mem_addr, sample_en, acc_clr, acc_en, out_valid}
  logic [16:0] obs;
  assign obs = {busy, done, tap_sel, mem_addr, sample_en, acc_clr, acc_en, out_valid};

  bit hp      [0:4095];
  bit ov_at   [0:4095];
  int t_issue [0:2047];

  folded_fir_ctrl #(.TAPS(TAPS), .TAP_W(TAP_W), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
    .clk100(clk100), .rstn(rstn), .start(start), .num_samples(num_samples), .hold(hold),
    .busy(busy), .done(done), .tap_sel(tap_sel), .mem_addr(mem_addr),
    .sample_en(sample_en), .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid)
`ifdef FOLDED_FIR_CTRL_COEF_REG_EN
    , .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata), .coef_out(coef_out)
`endif
  );

  always #5 clk100 = ~clk100;

  task automatic tick;
    @(posedge clk100);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs !== 17'h0) $display("FAIL reset_state: got %h expected %h", obs, 17'h0);
    else passes++;
    rstn = 1'b1;
    hold = 1'b1;
    tick();
    tick();
    hold = 1'b0;
    checks++;
    if (obs !== 17'h0) $display("FAIL idle_after_reset: got %h expected %h", obs, 17'h0);
    else passes++;
  endtask

  // N=3 with no hold, checked against closed-form cycle timing.
  task automatic test_basic;
    int n;
    int e;
    n = 3;
    e = n * TAPS + 1;
    start = 1'b1;
    num_samples = ADDR_W'(n);
    tick();
    start = 1'b0;
    for (int c = 1; c <= e + 1; c++) begin
      logic b, d, en, se, ov;
      logic [TAP_W-1:0] tp;
      logic [ADDR_W-1:0] ad;
      logic [16:0] exp;
      b  = (c <= n * TAPS);
      d  = (c == e);
      en = b;
      tp = b ? TAP_W'((c - 1) % TAPS) : '0;
      ad = b ? ADDR_W'((c - 1) / TAPS) : ADDR_W'(n);
      se = b && (((c - 1) % TAPS) == 0);
      ov = (c >= TAPS + 1) && (c <= e) && (((c - 1) % TAPS) == 0);
      exp = {b, d, tp, ad, se, se, en, ov};
      checks++;
      if (obs !== exp) $display("FAIL basic_c%0d: got %h expected %h", c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  task automatic test_hold;
    int cyc;
    start = 1'b1;
    num_samples = 8'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({tap_sel, acc_en} !== {3'd2, 1'b1}) $display("FAIL hold_pre: got tap=%0d en=%0b expected tap=2 en=1", tap_sel, acc_en);
    else passes++;
    hold = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, tap_sel, acc_en, sample_en} !== {1'b1, 3'd2, 1'b0, 1'b0})
        $display("FAIL hold_frozen_%0d: got busy=%0b tap=%0d en=%0b se=%0b expected 1,2,0,0", i, busy, tap_sel, acc_en, sample_en);
      else passes++;
      if (i == 2) hold = 1'b0;
      tick();
    end
    checks++;
    if ({tap_sel, acc_en} !== {3'd3, 1'b1}) $display("FAIL hold_resume: got tap=%0d en=%0b expected tap=3 en=1", tap_sel, acc_en);
    else passes++;
    cyc = 7;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 14) $display("FAIL hold_done_cycle: got %0d expected 14", cyc);
    else passes++;
  endtask

  task automatic test_restart;
    int cyc;
    start = 1'b1;
    num_samples = 8'd2;
    tick();
    start = 1'b0;
    cyc = 1;
    repeat (3) begin
      tick();
      cyc++;
    end
    start = 1'b1;
    num_samples = 8'd7;
    tick();
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 11) $display("FAIL restart_done_cycle: got %0d expected 11", cyc);
    else passes++;
    checks++;
    if (mem_addr !== 8'd2) $display("FAIL restart_addr: got %0d expected 2", mem_addr);
    else passes++;
    tick();
    start = 1'b1;
    num_samples = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, acc_en, out_valid} !== 4'b0100)
      $display("FAIL zero_start_pulse: got %b expected 0100", {busy, done, acc_en, out_valid});
    else passes++;
    tick();
    checks++;
    if ({busy, done, acc_en, out_valid} !== 4'b0000)
      $display("FAIL zero_start_after: got %b expected 0000", {busy, done, acc_en, out_valid});
    else passes++;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    start = 1'b1;
    num_samples = 8'd4;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (tap_sel !== 3'd3) $display("FAIL midrst_pre_tap: got %0d expected 3", tap_sel);
    else passes++;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 17'h0) $display("FAIL midrst_async: got %h expected %h", obs, 17'h0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 17'h0) $display("FAIL midrst_hold_%0d: got %h expected %h", i, obs, 17'h0);
      else passes++;
    end
    rstn = 1'b1;
    tick();
    start = 1'b1;
    num_samples = 8'd1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 6 || done !== 1'b1) $display("FAIL midrst_restart: got cycle %0d done=%0b expected cycle 6 done=1", cyc, done);
    else passes++;
  endtask

  // Random runs: the reference is a schedule of MAC issue times built from
  // the hold pattern (an issue follows the previous one at the first cycle
  // whose predecessor had hold low). Run 0 is the long N=252 case.
  task automatic test_random_runs(input int runs);
    for (int r = 0; r < runs; r++) begin
      int n, pct, issues, last, e, kk, ov_cnt, busy_cnt;
      n = (r == 0) ? 252 : int'($urandom_range(1, 12));
      pct = (r == 0) ? 0 : int'($urandom_range(0, 50));
      issues = n * TAPS;
      for (int tt = 0; tt < 4096; tt++) begin
        hp[tt] = (tt < 2000) && (int'($urandom_range(0, 99)) < pct);
        ov_at[tt] = 1'b0;
      end
      t_issue[0] = 1;
      for (int k = 1; k < issues; k++) begin
        int tt;
        tt = t_issue[k-1] + 1;
        while (hp[tt-1]) tt++;
        t_issue[k] = tt;
      end
      for (int k = TAPS - 1; k < issues; k += TAPS) ov_at[t_issue[k] + 1] = 1'b1;
      last = t_issue[issues-1];
      e = last + 1;
      kk = 0;
      ov_cnt = 0;
      busy_cnt = 0;
      start = 1'b1;
      num_samples = ADDR_W'(n);
      hold = hp[0];
      tick();
      start = 1'b0;
      for (int c = 1; c <= e + 1; c++) begin
        logic b, d, en, se, ov;
        logic [TAP_W-1:0] tp;
        logic [ADDR_W-1:0] ad;
        logic [16:0] exp;
        while (kk + 1 < issues && t_issue[kk+1] <= c) kk++;
        b  = (c <= last);
        d  = (c == e);
        ov = ov_at[c];
        en = b && (t_issue[kk] == c);
        tp = b ? TAP_W'(kk % TAPS) : '0;
        ad = b ? ADDR_W'(kk / TAPS) : ADDR_W'(n);
        se = en && ((kk % TAPS) == 0);
        exp = {b, d, tp, ad, se, se, en, ov};
        checks++;
        if (obs !== exp) $display("FAIL rand_r%0d_c%0d: got %h expected %h", r, c, obs, exp);
        else passes++;
        ov_cnt += int'(out_valid);
        busy_cnt += int'(busy);
        hold = hp[c];
        start = (c < e) && ($urandom_range(0, 9) == 0);
        num_samples = ADDR_W'($urandom);
        tick();
      end
      start = 1'b0;
      hold = 1'b0;
      checks++;
      if (ov_cnt !== n) $display("FAIL rand_r%0d_ov_count: got %0d expected %0d", r, ov_cnt, n);
      else passes++;
      checks++;
      if (busy_cnt !== last) $display("FAIL rand_r%0d_busy_count: got %0d expected %0d", r, busy_cnt, last);
      else passes++;
    end
  endtask

`ifdef FOLDED_FIR_CTRL_COEF_REG_EN
  task automatic test_coef;
    logic [COEF_W-1:0] tbl [0:TAPS-1];
    tbl = '{12'h25D, 12'hC9D, 12'h41D, 12'hCA0, 12'h652};
    for (int i = 0; i < TAPS; i++) begin
      coef_we = 1'b1;
      coef_waddr = TAP_W'(i);
      coef_wdata = tbl[i];
      tick();
    end
    coef_waddr = 3'd5;
    coef_wdata = 12'h7FF;
    tick();
    coef_we = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      num_samples = 8'd1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= TAPS; c++) begin
        checks++;
        if ({tap_sel, coef_out} !== {TAP_W'(c - 1), tbl[c-1]})
          $display("FAIL coef_p%0d_c%0d: got tap=%0d coef=%h expected tap=%0d coef=%h", pass, c, tap_sel, coef_out, c - 1, tbl[c-1]);
        else passes++;
        coef_we = (c == 2);
        coef_waddr = 3'd2;
        coef_wdata = 12'h7FF;
        tick();
      end
      coef_we = 1'b0;
      tick();
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_restart();
    test_reset_mid_run();
    test_random_runs(8);
`ifdef FOLDED_FIR_CTRL_COEF_REG_EN
    test_coef();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/folded_fir_ctrl.md
Name: folded_fir_ctrl

Overview:
- Sequencer for the 5-tap folded FIR datapath, which has one shared 12x22-bit MAC.
- Runs on the single fast clock (clk100) and replaces the separate clk20 sample clock with a one-cycle sample_en strobe every TAPS cycles.
- Issues the tap select, input-memory address, accumulator clear/enable and output-valid strobes for a programmed number of samples, using a start/done handshake plus a hold (stall) input.

Parameters:
- TAPS, 5, MAC cycles per sample (number of coefficients).
- TAP_W, 3, width of tap_sel; must satisfy 2^TAP_W >= TAPS.
- ADDR_W, 8, width of input-memory address and sample count.
- COEF_W, 12, coefficient width; used only with the optional feature.

Ports:
- clk100  in  1  system clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled only in IDLE.
- num_samples  in  ADDR_W  samples to process; captured when start is accepted.
- hold  in  1  stall; freezes the sequence while high.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- tap_sel  out  TAP_W  coefficient / delay-line tap index for the current MAC cycle.
- mem_addr  out  ADDR_W  input-memory read address of the current sample.
- sample_en  out  1  shift delay line / load new sample (issued with tap 0).
- acc_clr  out  1  accumulator loads the product instead of adding it (issued with tap 0).
- acc_en  out  1  MAC cycle active.
- out_valid  out  1  accumulator holds a finished output; latch it.

Behaviour:
- All outputs are registered. On rstn=0, asynchronously:
  - state=IDLE
  - busy, done, sample_en, acc_clr, acc_en, out_valid all = 0
  - tap_sel=0, mem_addr=0
- States: IDLE, RUN.
- IDLE:
  - start=1 with num_samples>0: capture N=num_samples and go to RUN. In the next cycle: tap_sel=0, mem_addr=0, sample_en=1, acc_clr=1, acc_en=1, busy=1.
  - start=1 with num_samples=0: stay in IDLE and pulse done for one cycle (no busy, no out_valid).
- RUN, in each cycle with hold=0 (an "issue" cycle, acc_en=1):
  - If tap_sel < TAPS-1: tap_sel increments.
  - If tap_sel = TAPS-1: tap_sel wraps to 0, mem_addr increments, and out_valid=1 in the following cycle.
  - sample_en and acc_clr are 1 exactly in the tap_sel=0 issue cycles.
- End of run: after tap TAPS-1 of sample N-1 is issued, the next cycle has out_valid=1, done=1, busy=0, acc_en=0, state=IDLE. tap_sel returns to 0; mem_addr holds N.
- Timing without hold, counting the start cycle as cycle 0:
  - first tap-0 issue in cycle 1;
  - out_valid in cycles k*TAPS+1 for k=1..N;
  - busy high in cycles 1..N*TAPS;
  - done in cycle N*TAPS+1.
  - Sample period is TAPS clk100 cycles (100 MHz / 5 = 20 MHz).
- hold=1 in RUN:
  - Next cycle: acc_en, sample_en and acc_clr = 0; tap_sel and mem_addr keep their values; busy stays 1.
  - When hold drops, the sequence resumes at the same tap with no cycle lost or repeated.
  - A pending out_valid (set by the previous issue of tap TAPS-1) is still produced even if hold rises that cycle.
- hold in IDLE: no effect.
- start while busy: ignored; num_samples is not recaptured.
- Address arithmetic: mem_addr is unsigned modulo 2^ADDR_W. N=2^ADDR_W-1 is the maximum run.
- Reset mid-run: immediate return to IDLE with all outputs at reset values; any partial output is discarded (no out_valid, no done).

Optional Feature:
- Macro: FOLDED_FIR_CTRL_COEF_REG_EN
- Defined:
  - Adds an internal bank of TAPS signed COEF_W-bit registers, reset to 0.
  - Adds write port coef_we (in, 1), coef_waddr (in, TAP_W), coef_wdata (in, COEF_W).
  - Adds output coef_out (out, COEF_W), which is always registered coef[tap_sel] and aligned with tap_sel.
  - Writes are accepted only when busy=0 and coef_waddr < TAPS; otherwise they are ignored.
- Undefined:
  - None of these ports or registers exist.
  - The datapath muxes the external c0..c4 using tap_sel.

Test Plan:
- Reset then start with num_samples=3 and hold=0 → tap_sel sequence 0,1,2,3,4 repeated 3 times; out_valid in cycles 6, 11, 16; done and busy=0 in cycle 16; mem_addr ends at 3.
- Run with num_samples=252 and hold=0 → 252 out_valid pulses, each 5 cycles apart; busy high for exactly 1260 cycles; mem_addr reaches 252.
- Start with num_samples=2; hold=1 for 3 cycles while tap_sel=2 → tap_sel stays 2 and acc_en=0 for 3 cycles, then continues at 3; done is delayed by exactly 3 cycles, to cycle 14.
- Raise start again in cycle 4 of an N=2 run; separately start with num_samples=0 → the second start is ignored (done still in cycle 11); the num_samples=0 start gives a one-cycle done and no busy.
- Assert rstn=0 mid-run at tap_sel=3 and release, then start with N=1 → all outputs 0 during reset with no done or out_valid; after restart, out_valid and done in cycle 6.
- With FOLDED_FIR_CTRL_COEF_REG_EN: write 0x25D, 0xC9D, 0x41D, 0xCA0, 0x652 to addresses 0..4, then run N=1 → coef_out follows 0x25D, 0xC9D, 0x41D, 0xCA0, 0x652 alongside tap_sel; a write attempted while busy leaves the bank unchanged.
